// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: IR fields, status inputs and control outputs between controller and datapath
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memReady;
  logic       iorD;
  logic       irWrite;
  logic       pcEn;
  logic       memWrite;
  logic       regWrite;
  logic       regDst;
  logic       memToReg;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] pcSrc;
  logic [3:0] aluControl;
  logic       branch;
  logic [3:0] state;
  logic       illegalOp;
  logic       memTimeout;
  modport master (
    input  op, funct, zero, memReady,
    output iorD, irWrite, pcEn, memWrite, regWrite, regDst, memToReg, aluSrcA,
           aluSrcB, pcSrc, aluControl, branch, state, illegalOp, memTimeout
  );
  modport slave (
    output op, funct, zero, memReady,
    input  iorD, irWrite, pcEn, memWrite, regWrite, regDst, memToReg, aluSrcA,
           aluSrcB, pcSrc, aluControl, branch, state, illegalOp, memTimeout
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with memory-ready stalls, timeout and illegal-op halt
module mips_multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input logic                   i_clk,
  input logic                   i_reset,
  mips_multicycle_ctrl_if.master bus
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7,
                         BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11,
                         HALT = 4'd15;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0110, ALU_SLT = 4'b0111;
  logic [3:0] r_state, w_next, w_st;
  logic [7:0] r_wait, w_wait_next;
  logic       r_illegal, r_timeout, w_illegal_set, w_timeout_set;
  logic       w_wait_st, w_expire, w_rtype_ok, w_pc_write;
  logic [3:0] w_rtype_alu;
  assign w_rtype_ok = bus.funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  assign w_rtype_alu = bus.funct == 6'b100010 ? ALU_SUB :
                       bus.funct == 6'b100100 ? ALU_AND :
                       bus.funct == 6'b100101 ? ALU_OR  :
                       bus.funct == 6'b101010 ? ALU_SLT : ALU_ADD;
  assign w_wait_st = r_state inside {FETCH, MEMRD, MEMWR};
  // a ready in the final allowed wait cycle still advances normally
  assign w_expire = w_wait_st && !bus.memReady && r_wait == 8'(TIMEOUT - 1);
  assign w_wait_next = (w_wait_st && !bus.memReady && !w_expire) ? r_wait + 8'd1 : 8'd0;
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= FETCH;
      r_wait    <= 8'd0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wait    <= w_wait_next;
      r_illegal <= r_illegal | w_illegal_set;
      r_timeout <= r_timeout | w_timeout_set;
    end
  end
  always_comb begin
    w_next = r_state;
    w_illegal_set = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      FETCH:  w_next = bus.memReady ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          6'b100011, 6'b101011: w_next = MEMADR;
          6'b000000:            w_next = w_rtype_ok ? EXEC : HALT;
          6'b000100:            w_next = BRANCH;
          6'b001000:            w_next = ADDIEX;
          6'b000010:            w_next = JUMP;
          default:              w_next = HALT;
        endcase
        w_illegal_set = w_next == HALT;
      end
      MEMADR: w_next = bus.op[3] ? MEMWR : MEMRD;
      MEMRD:  w_next = bus.memReady ? MEMWB : MEMRD;
      MEMWR:  w_next = bus.memReady ? FETCH : MEMWR;
      EXEC:   w_next = ALUWB;
      ADDIEX: w_next = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: w_next = FETCH;
      default: w_next = HALT;
    endcase
    if (w_expire) begin
      w_next = HALT;
      w_timeout_set = 1'b1;
    end
  end
  // while in reset, decode as HALT so every strobe and select reads 0
  assign w_st = i_reset ? r_state : HALT;
  always_comb begin
    w_pc_write = 1'b0;
    bus.iorD = 1'b0;
    bus.irWrite = 1'b0;
    bus.memWrite = 1'b0;
    bus.regWrite = 1'b0;
    bus.regDst = 1'b0;
    bus.memToReg = 1'b0;
    bus.aluSrcA = 1'b0;
    bus.aluSrcB = 2'b00;
    bus.pcSrc = 2'b00;
    bus.aluControl = ALU_AND;
    bus.branch = 1'b0;
    case (w_st)
      FETCH: begin
        bus.aluSrcB = 2'b01;
        bus.aluControl = ALU_ADD;
        bus.irWrite = bus.memReady;
        w_pc_write = bus.memReady;
      end
      DECODE: begin
        bus.aluSrcB = 2'b11;
        bus.aluControl = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
        bus.aluControl = ALU_ADD;
      end
      MEMRD: bus.iorD = 1'b1;
      MEMWB: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 1'b1;
      end
      MEMWR: begin
        bus.iorD = 1'b1;
        bus.memWrite = 1'b1;
      end
      EXEC: begin
        bus.aluSrcA = 1'b1;
        bus.aluControl = w_rtype_alu;
      end
      ALUWB: begin
        bus.regWrite = 1'b1;
        bus.regDst = 1'b1;
      end
      BRANCH: begin
        bus.aluSrcA = 1'b1;
        bus.aluControl = ALU_SUB;
        bus.branch = 1'b1;
        bus.pcSrc = 2'b01;
      end
      ADDIWB: bus.regWrite = 1'b1;
      JUMP: begin
        bus.pcSrc = 2'b10;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
    bus.pcEn = w_pc_write | (bus.branch & bus.zero);
  end
  assign bus.state = i_reset ? r_state : 4'd0;
  assign bus.illegalOp = i_reset & r_illegal;
  assign bus.memTimeout = i_reset & r_timeout;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed and randomized instruction streams checked against a per-instruction cycle model
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_flags;
  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110;
  mips_multicycle_ctrl_if bus();
  mips_multicycle_ctrl #(.TIMEOUT(16)) dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [16:0] cw(bit iord = 0, bit irw = 0, bit pce = 0, bit mw = 0,
                                     bit rw = 0, bit rd = 0, bit m2r = 0, bit sa = 0,
                                     logic [1:0] sb = 2'b00, logic [1:0] ps = 2'b00,
                                     logic [3:0] alu = 4'b0000, bit br = 0);
    return {iord, irw, pce, mw, rw, rd, m2r, sa, sb, ps, alu, br};
  endfunction
  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      default:   return 4'b0111;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit mr, input logic [3:0] st, input logic [16:0] c, input string tag);
    bus.memReady = mr;
    #1;
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".ctl"}, 32'({bus.iorD, bus.irWrite, bus.pcEn, bus.memWrite, bus.regWrite, bus.regDst,
                            bus.memToReg, bus.aluSrcA, bus.aluSrcB, bus.pcSrc, bus.aluControl,
                            bus.branch}), 32'(c));
    chk({tag, ".flags"}, 32'({bus.illegalOp, bus.memTimeout}), 32'(exp_flags));
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.op = 6'($urandom);
      bus.funct = 6'($urandom);
      bus.zero = 1'($urandom);
      exp_flags = 2'b00;
      step(1'($urandom), 4'd0, cw(), "reset");
    end
    rst_n = 1'b1;
  endtask
  task automatic fetch_decode(input int fs);
    for (int i = 0; i < fs; i++) step(1'b0, 4'd0, cw(.sb(2'b01), .alu(ADD)), "fetch_wait");
    step(1'b1, 4'd0, cw(.irw(1), .pce(1), .sb(2'b01), .alu(ADD)), "fetch");
    step(1'($urandom), 4'd1, cw(.sb(2'b11), .alu(ADD)), "decode");
  endtask
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int fs, input int ms);
    bus.op = op;
    bus.funct = fn;
    bus.zero = z;
    fetch_decode(fs);
    case (op)
      6'b100011: begin
        step(1'($urandom), 4'd2, cw(.sa(1), .sb(2'b10), .alu(ADD)), "lw_adr");
        for (int i = 0; i < ms; i++) step(1'b0, 4'd3, cw(.iord(1)), "lw_rd_wait");
        step(1'b1, 4'd3, cw(.iord(1)), "lw_rd");
        step(1'($urandom), 4'd4, cw(.rw(1), .m2r(1)), "lw_wb");
      end
      6'b101011: begin
        step(1'($urandom), 4'd2, cw(.sa(1), .sb(2'b10), .alu(ADD)), "sw_adr");
        for (int i = 0; i < ms; i++) step(1'b0, 4'd5, cw(.iord(1), .mw(1)), "sw_wr_wait");
        step(1'b1, 4'd5, cw(.iord(1), .mw(1)), "sw_wr");
      end
      6'b000000: begin
        step(1'($urandom), 4'd6, cw(.sa(1), .alu(alu_of(fn))), "r_exec");
        step(1'($urandom), 4'd7, cw(.rw(1), .rd(1)), "r_wb");
      end
      6'b000100: step(1'($urandom), 4'd8, cw(.pce(z), .sa(1), .ps(2'b01), .alu(SUB), .br(1)), "beq");
      6'b001000: begin
        step(1'($urandom), 4'd9, cw(.sa(1), .sb(2'b10), .alu(ADD)), "addi_ex");
        step(1'($urandom), 4'd10, cw(.rw(1)), "addi_wb");
      end
      default: step(1'($urandom), 4'd11, cw(.pce(1), .ps(2'b10)), "jump");
    endcase
  endtask
  task automatic expect_halt(input int n);
    for (int i = 0; i < n; i++) begin
      bus.zero = 1'($urandom);
      step(1'($urandom), 4'd15, cw(), "halt");
    end
  endtask
  initial begin
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    bus.op = 6'd0;
    bus.funct = 6'd0;
    bus.zero = 1'b0;
    bus.memReady = 1'b0;
    exp_flags = 2'b00;
    do_reset();
    run_instr(6'b100011, 6'd0, 1'b0, 0, 0);
    run_instr(6'b101011, 6'd0, 1'b0, 0, 3);
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0);
    run_instr(6'b000100, 6'd0, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b101010, 1'b0, 1, 0);
    run_instr(6'b001000, 6'd0, 1'b0, 2, 0);
    run_instr(6'b000010, 6'd0, 1'b0, 0, 0);
    for (int k = 0; k < 40; k++)
      run_instr(ops[$urandom_range(0, 5)], fns[$urandom_range(0, 4)], 1'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 6));
    bus.op = 6'b111111;
    fetch_decode(0);
    exp_flags = 2'b10;
    expect_halt(4);
    do_reset();
    bus.op = 6'b000000;
    bus.funct = 6'b000000;
    fetch_decode(1);
    exp_flags = 2'b10;
    expect_halt(3);
    do_reset();
    bus.op = 6'b101011;
    fetch_decode(0);
    step(1'b0, 4'd2, cw(.sa(1), .sb(2'b10), .alu(ADD)), "abort_adr");
    step(1'b0, 4'd5, cw(.iord(1), .mw(1)), "abort_wr");
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b0, 4'd0, cw(.sb(2'b01), .alu(ADD)), "to_wait");
    exp_flags = 2'b01;
    expect_halt(3);
    do_reset();
    run_instr(6'b001000, 6'd0, 1'b0, 15, 0);
    run_instr(6'b100011, 6'd0, 1'b0, 0, 15);
    run_instr(6'b101011, 6'd0, 1'b0, 0, 15);
    bus.op = 6'b100011;
    fetch_decode(0);
    step(1'b0, 4'd2, cw(.sa(1), .sb(2'b10), .alu(ADD)), "to_rd_adr");
    for (int i = 0; i < 16; i++) step(1'b0, 4'd3, cw(.iord(1)), "to_rd_wait");
    exp_flags = 2'b01;
    expect_halt(2);
    do_reset();
    run_instr(6'b000010, 6'd0, 1'b0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
